// File: rtl/i2c_master_lite.sv
// ============================================================================
// i2c_master_lite
// ----------------------------------------------------------------------------
// Byte-level I2C master for a MAC-EEPROM-style sink: START, address byte,
// register byte (writes only), up to two data bytes, STOP. It drives the
// SCL/SDA open-drain IOBUF pins directly.
//
// Parameters:
//   QTR        clk cycles per quarter SCL period (>= 2)
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start                    command strobe, sampled only while busy=0
//   dev_addr[6:0], rw        target address and direction (1 = read)
//   mem_addr[7:0]            register byte, written on writes only
//   wr_data[15:0]            write bytes, [15:8] first
//   nbytes[1:0]              data bytes 0..2 (3 clamps to 2)
//   rd_data[15:0]            read result (1 byte: {00,b0}; 2 bytes: {b0,b1})
//   busy, done, ack_err      status; done is a one-cycle pulse
//   scl_i, sda_i             pad input levels
//   scl_o, sda_o             tied low (open-drain)
//   scl_t, sda_t             1 = release, 0 = drive low (registered)
//   dbg_state[2:0]           current FSM state, for observation only
//
// Command handshake: start is honoured only in a cycle where busy=0; the
// command inputs are captured in that cycle, busy rises on the next cycle
// and stays high until the cycle in which done pulses (busy=0, done=1 in
// the same cycle). A start seen while busy=1 is dropped, never queued.
//
// Optional feature: define I2C_MASTER_STRETCH_EN to let a slave stretch
// SCL; the quarter counter then stalls while SCL is released but still
// reads low. Without it scl_i is ignored and timing is fixed.
// ============================================================================
module i2c_master_lite #(
    parameter int QTR = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  dev_addr,
    input  logic        rw,
    input  logic [7:0]  mem_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  nbytes,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        scl_o,
    output logic        sda_o,
    output logic        scl_t,
    output logic        sda_t,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_BIT    = 3'd2;
    localparam logic [2:0] S_ACK_RX = 3'd3;
    localparam logic [2:0] S_ACK_TX = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    localparam int CW = $clog2(2 * QTR);
    localparam logic [CW-1:0] Q_END   = CW'(QTR - 1);
    localparam logic [CW-1:0] TWO_END = CW'(2 * QTR - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_phase;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte_idx;
    logic [1:0]    r_last_idx;
    logic          r_rw;
    logic [6:0]    r_dev;
    logic [7:0]    r_mem;
    logic [15:0]   r_wr;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx;
    logic          r_ack;
    logic [15:0]   r_rd;
    logic          r_busy;
    logic          r_done;
    logic          r_ack_err;
    logic          r_scl_t;
    logic          r_sda_t;

    logic [1:0]    w_nd;
    logic [1:0]    w_last;
    logic [1:0]    w_nxt_idx;
    logic [7:0]    w_nxt_byte;
    logic          w_is_tx;
    logic          w_is_last;
    logic          w_hold;
    logic          w_q_end;
    logic          w_bitlike;

    // Data-byte count and index of the final wire byte for the command
    // being accepted (read with zero bytes still reads one).
    always_comb begin
        w_nd = (nbytes == 2'd3) ? 2'd2 : nbytes;
        if (rw && (w_nd == 2'd0)) begin
            w_nd = 2'd1;
        end
        w_last = rw ? w_nd : (w_nd + 2'd1);
    end

    // Byte that follows the current one. Received bytes load all-ones so
    // SDA stays released while the slave drives.
    always_comb begin
        w_nxt_idx  = r_byte_idx + 2'd1;
        w_nxt_byte = 8'hFF;
        if (!r_rw) begin
            case (w_nxt_idx)
                2'd1:    w_nxt_byte = r_mem;
                2'd2:    w_nxt_byte = r_wr[15:8];
                2'd3:    w_nxt_byte = r_wr[7:0];
                default: w_nxt_byte = 8'hFF;
            endcase
        end
    end

    assign w_is_tx   = !r_rw || (r_byte_idx == 2'd0);
    assign w_is_last = (r_byte_idx == r_last_idx);
    assign w_bitlike = (r_state == S_BIT) || (r_state == S_ACK_RX) ||
                       (r_state == S_ACK_TX);

`ifdef I2C_MASTER_STRETCH_EN
    // Stall while SCL is released but a slave still holds it low.
    assign w_hold = r_scl_t && !scl_i &&
                    ((w_bitlike && r_phase[1]) ||
                     ((r_state == S_STOP) && (r_phase == 2'd1)));
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_i;
    assign w_hold       = 1'b0;
`endif

    assign w_q_end = (r_cnt == Q_END) && !w_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_phase    <= 2'd0;
            r_bit      <= 3'd0;
            r_byte_idx <= 2'd0;
            r_last_idx <= 2'd0;
            r_rw       <= 1'b0;
            r_dev      <= 7'd0;
            r_mem      <= 8'd0;
            r_wr       <= 16'd0;
            r_shift    <= 8'hFF;
            r_rx       <= 8'd0;
            r_ack      <= 1'b0;
            r_rd       <= 16'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_scl_t    <= 1'b1;
            r_sda_t    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rw       <= rw;
                        r_dev      <= dev_addr;
                        r_mem      <= mem_addr;
                        r_wr       <= wr_data;
                        r_last_idx <= w_last;
                        r_rd       <= 16'd0;
                        r_ack_err  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_sda_t    <= 1'b0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt == TWO_END) begin
                        r_cnt      <= '0;
                        r_phase    <= 2'd0;
                        r_bit      <= 3'd0;
                        r_byte_idx <= 2'd0;
                        r_shift    <= {r_dev, r_rw};
                        r_sda_t    <= r_dev[6];
                        r_scl_t    <= 1'b0;
                        r_state    <= S_BIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_BIT, S_ACK_RX, S_ACK_TX: begin
                    if (!w_q_end) begin
                        if (!w_hold) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            2'd1: r_scl_t <= 1'b1;
                            2'd2: begin
                                r_ack <= sda_i;
                                if (r_state == S_BIT) begin
                                    r_rx <= {r_rx[6:0], sda_i};
                                end
                            end
                            2'd3: begin
                                // End of q3 is the entry of the next q0:
                                // SCL falls and SDA takes its next value.
                                r_scl_t <= 1'b0;
                                if (r_state == S_BIT) begin
                                    if (r_bit == 3'd7) begin
                                        r_bit <= 3'd0;
                                        if (w_is_tx) begin
                                            r_sda_t <= 1'b1;
                                            r_state <= S_ACK_RX;
                                        end else begin
                                            // ACK every received byte but the last.
                                            r_sda_t <= w_is_last;
                                            r_state <= S_ACK_TX;
                                            if (r_byte_idx == 2'd1) begin
                                                r_rd <= {8'h00, r_rx};
                                            end else begin
                                                r_rd <= {r_rd[7:0], r_rx};
                                            end
                                        end
                                    end else begin
                                        r_bit   <= r_bit + 3'd1;
                                        r_sda_t <= r_shift[6];
                                        r_shift <= {r_shift[6:0], 1'b1};
                                    end
                                end else if (((r_state == S_ACK_RX) && r_ack) || w_is_last) begin
                                    if ((r_state == S_ACK_RX) && r_ack) begin
                                        r_ack_err <= 1'b1;
                                    end
                                    r_sda_t <= 1'b0;
                                    r_state <= S_STOP;
                                end else begin
                                    r_byte_idx <= w_nxt_idx;
                                    r_shift    <= w_nxt_byte;
                                    r_sda_t    <= w_nxt_byte[7];
                                    r_state    <= S_BIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (!w_q_end) begin
                        if (!w_hold) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            2'd0: r_scl_t <= 1'b1;
                            2'd1: r_sda_t <= 1'b1;
                            default: begin
                                r_phase <= 2'd0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data   = r_rd;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_err   = r_ack_err;
    assign scl_o     = 1'b0;
    assign sda_o     = 1'b0;
    assign scl_t     = r_scl_t;
    assign sda_t     = r_sda_t;
    assign dbg_state = r_state;

endmodule

// File: doc/i2c_master_lite.md
# i2c_master_lite

Byte-level I2C master that generates the START / address / register / data / STOP sequences consumed by the on-board MAC-EEPROM-style I2C sink (7-bit device address, 8-bit memory address, up to two data bytes). Sits between fabric control logic (command strobe plus captured read data) and the SCL/SDA open-drain IOBUF pins. It drives the bus directly in place of the PS I2C controller for bring-up and self-test.

## Interface
Parameters:
- QTR, 250, clk cycles per quarter SCL period (100 kHz SCL at 100 MHz clk); legal range ≥ 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- dev_addr  in  7  target device address.
- rw  in  1  1 = read, 0 = write.
- mem_addr  in  8  register byte, sent on writes only.
- wr_data  in  16  write bytes; [15:8] sent first.
- nbytes  in  2  data bytes, 0..2; value 3 clamps to 2.
- rd_data  out  16  read result.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- ack_err  out  1  NACK seen in the last transaction.
- scl_i / sda_i  in  1  pad input levels.
- scl_o / sda_o  out  1  tied 0 (open-drain).
- scl_t / sda_t  out  1  1 = release (pulled high), 0 = drive low; registered.

## Operation
- Reset values: busy=0, done=0, ack_err=0, rd_data=0, scl_t=1, sda_t=1, state IDLE.
- IDLE: on start=1, latch all command inputs, clear rd_data and ack_err, set busy the next cycle, and go to START. Read with nbytes=0 is treated as 1.
- START: with SCL released, pull SDA low for 2Q, then go to BIT.
- BIT: shift the current byte MSB-first. Phase counter q0..q3 (Q = QTR cycles each):
  - q0: SCL low; SDA set at q0 entry.
  - q1: SCL low.
  - q2: SCL released; sda_i sampled on the last cycle of q2.
  - q3: SCL released.
- Byte order:
  - Write: {dev_addr,0}, mem_addr, then nbytes data bytes.
  - Read: {dev_addr,1}, then nbytes received bytes.
- After each transmitted byte, go to ACK_RX: SDA released for one bit time, sda_i sampled at q2.
  - Sampled 1: set ack_err and go to STOP; remaining bytes are skipped.
- After each received byte, go to ACK_TX: drive SDA low (ACK) for all but the last byte; release SDA (NACK) for the last byte.
- rd_data layout:
  - 1-byte read: {8'h00, b0}.
  - 2-byte read: {b0, b1}.
- STOP: SDA low with SCL low for Q, release SCL for Q, release SDA for Q, then return to IDLE. done=1 and busy=0 in that same cycle.
- start while busy=1 is ignored; there is no queuing.

## Timing
- B = total bytes on the wire, including the address byte.
  - Write: B = 2 + nbytes.
  - Read: B = 1 + max(nbytes, 1).
- Without stretching, busy stays high for exactly (5 + 36·B)·Q cycles.
- done pulses exactly once per accepted start, including NACK-aborted transactions.
- After a NACK on byte k, B in the formula above is k.
- rst mid-transaction: scl_t=sda_t=1 on the next cycle and all outputs return to reset values. No STOP is generated; the next START re-syncs the slave.
- SDA changes only while SCL is low, except in the START and STOP phases.

## Configuration
- I2C_MASTER_STRETCH_EN defined:
  - In q2 and q3, and in the STOP SCL-release quarter, the phase counter holds while scl_i=0 after scl_t=1 (slave clock stretching).
  - The busy-cycle formula becomes a minimum.
- Not defined: scl_i is unused and timing is fixed exactly by the formula.

## Test plan
- Write to sink model: dev 0x50, mem 0x10, nbytes=2, wr_data=0xABCD.
  - Expect wire bytes A0, 10, AB, CD, all ACKed.
  - Expect the sink to capture mem_addr=0x10, data_in=0xABCD.
  - Expect ack_err=0 and busy high for 149·Q cycles.
- Read from sink model: dev 0x50, nbytes=1.
  - Expect wire byte A1, then a received byte.
  - Expect rd_data=0x00C3, master NACK on the last byte, then STOP, done=1.
- No slave (sda_i held 1): write to dev 0x22.
  - Expect ack_err=1 after the first byte and STOP immediately.
  - Expect busy high for 41·Q cycles, done=1.
- start pulsed at cycle 10 of an active transaction.
  - Expect it ignored: a single done pulse and unchanged wire traffic.
- rst asserted during bit 4 of the mem_addr byte.
  - Expect scl_t=sda_t=1, busy=0, and rd_data=0 on the next cycle.
  - A following write completes correctly.
- With I2C_MASTER_STRETCH_EN: slave holds SCL low for 1000 cycles during the first q2.
  - Expect no SDA change during the hold and busy extended by 1000 cycles.
